// File: rtl/nn_image_streamer_pkg.sv
// Shared definitions for the NN image streamer: state encoding, default
// sizes shared with NN_Controler, and word/counter sizing helpers.
package nn_image_streamer_pkg;

    localparam int DEF_INPUT_LAYER_NODES = 784;
    localparam int DEF_WORD_WIDTH        = 8;
    localparam int DEF_PRED_WIDTH        = 4;
    localparam int DEF_TIMEOUT_CYCLES    = 4096;

    typedef enum logic [2:0] {
        LOAD,
        WAIT_RDY,
        STREAM,
        WAIT_PRED,
        ACK,
        RESULT
    } state_e;

    // ceil(nodes / width): host words per image
    function automatic int num_words(input int nodes, input int width);
        return (nodes + width - 1) / width;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nn_image_buffer.sv
// Image buffer: word-wide writes at wordCount, single-bit reads at pixCount.
// Both counters live here so the top only sequences write/advance/clear.
module nn_image_buffer
    import nn_image_streamer_pkg::*;
#(
    parameter int NODES      = DEF_INPUT_LAYER_NODES,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  rd_adv,
    output logic                  last_word,
    output logic                  last_pix,
    output logic                  rd_bit
);

    localparam int NW   = num_words(NODES, WORD_WIDTH);
    localparam int WCW  = cnt_w(NW);
    localparam int PCW  = cnt_w(NODES);
    localparam int MEMW = NW * WORD_WIDTH;

    logic [MEMW-1:0] mem_q, mem_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic [PCW-1:0]  pcnt_q, pcnt_d;

    always_comb begin
        mem_d  = mem_q;
        wcnt_d = wcnt_q;
        pcnt_d = pcnt_q;
        if (clr) begin
            wcnt_d = '0;
            pcnt_d = '0;
        end else begin
            if (wr_en) begin
                mem_d[int'(wcnt_q)*WORD_WIDTH +: WORD_WIDTH] = wr_data;
                wcnt_d = wcnt_q + WCW'(1);
            end
            if (rd_adv) begin
                pcnt_d = pcnt_q + PCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            wcnt_q <= '0;
            pcnt_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wcnt_q <= wcnt_d;
            pcnt_q <= pcnt_d;
        end
    end

    // Padding bits of the last word are stored but never read.
    assign last_word = (wcnt_q == WCW'(NW - 1));
    assign last_pix  = (pcnt_q == PCW'(NODES - 1));
    assign rd_bit    = mem_q[pcnt_q];

endmodule

// File: rtl/nn_image_streamer.sv
// Host-side driver for NN_Controler: buffers an image, streams it, returns
// the prediction. Optional watchdog enabled with NN_STREAM_TIMEOUT_EN.
module nn_image_streamer
    import nn_image_streamer_pkg::*;
#(
    parameter int INPUT_LAYER_NODES = DEF_INPUT_LAYER_NODES,
    parameter int WORD_WIDTH        = DEF_WORD_WIDTH,
    parameter int PRED_WIDTH        = DEF_PRED_WIDTH,
    parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
    input  logic                  masterClk,
    input  logic                  resetN,
    input  logic [WORD_WIDTH-1:0] pixelWord,
    input  logic                  pixelValid,
    output logic                  pixelReady,
    input  logic                  readyForInputs,
    output logic                  inputsInbound,
    output logic                  inputPixel,
    input  logic                  predictionReady,
    input  logic [PRED_WIDTH-1:0] predictionOut,
    output logic                  predictionRecieved,
    output logic                  resultValid,
    output logic [PRED_WIDTH-1:0] resultClass,
    input  logic                  resultAck,
    output logic                  timeoutErr
);

    state_e                state_q, state_d;
    logic [PRED_WIDTH-1:0] res_q, res_d;

    logic wr_en;
    logic rd_adv;
    logic clr;
    logic last_word;
    logic last_pix;
    logic rd_bit;

`ifdef NN_STREAM_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
    logic           to_err_q, to_err_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    nn_image_buffer #(
        .NODES      (INPUT_LAYER_NODES),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_buf (
        .clk       (masterClk),
        .rst_n     (resetN),
        .clr       (clr),
        .wr_en     (wr_en),
        .wr_data   (pixelWord),
        .rd_adv    (rd_adv),
        .last_word (last_word),
        .last_pix  (last_pix),
        .rd_bit    (rd_bit)
    );

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        wr_en   = 1'b0;
        rd_adv  = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (pixelValid) begin
                    wr_en = 1'b1;
                    if (last_word) state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                if (readyForInputs) state_d = STREAM;
            end
            STREAM: begin
                rd_adv = 1'b1;
                if (last_pix) state_d = WAIT_PRED;
            end
            WAIT_PRED: begin
                if (predictionReady) begin
                    res_d   = predictionOut;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!predictionReady) state_d = RESULT;
            end
            RESULT: begin
                if (resultAck) begin
                    clr     = 1'b1;
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase

`ifdef NN_STREAM_TIMEOUT_EN
        to_cnt_d = '0;
        to_err_d = to_err_q;
        // Watchdog overrides any handshake progress on its final cycle.
        if (state_q == WAIT_PRED || state_q == ACK) begin
            if (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
                to_err_d = 1'b1;
                res_d    = '1;
                state_d  = RESULT;
            end else begin
                to_cnt_d = to_cnt_q + TOW'(1);
            end
        end
`endif
    end

    always_ff @(posedge masterClk or negedge resetN) begin
        if (!resetN) begin
            state_q <= LOAD;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

`ifdef NN_STREAM_TIMEOUT_EN
    always_ff @(posedge masterClk or negedge resetN) begin
        if (!resetN) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign timeoutErr = to_err_q;
`else
    assign timeoutErr = 1'b0;
`endif

    // Outputs decode straight from the state register so reset acts at once.
    assign pixelReady         = (state_q == LOAD);
    assign inputsInbound      = (state_q == STREAM);
    assign inputPixel         = (state_q == STREAM) & rd_bit;
    assign predictionRecieved = (state_q == ACK);
    assign resultValid        = (state_q == RESULT);
    assign resultClass        = res_q;

endmodule

// File: tb/tb_nn_image_streamer.sv
// Scoreboard bench for nn_image_streamer with a 6-pixel, 4-bit-word image.
// Timeout scenario runs only when NN_STREAM_TIMEOUT_EN is defined.
module tb_nn_image_streamer;

    localparam int N  = 6;
    localparam int WW = 4;
    localparam int PW = 4;
    localparam int TO = 16;

    logic          masterClk = 1'b0;
    logic          resetN = 1'b0;
    logic [WW-1:0] pixelWord = '0;
    logic          pixelValid = 1'b0;
    logic          pixelReady;
    logic          readyForInputs = 1'b0;
    logic          inputsInbound;
    logic          inputPixel;
    logic          predictionReady = 1'b0;
    logic [PW-1:0] predictionOut = '0;
    logic          predictionRecieved;
    logic          resultValid;
    logic [PW-1:0] resultClass;
    logic          resultAck = 1'b0;
    logic          timeoutErr;

    int   total = 0;
    int   bad = 0;
    int   blen = 0;
    logic exp_q[$];

    always #5 masterClk = ~masterClk;

    nn_image_streamer #(
        .INPUT_LAYER_NODES (N),
        .WORD_WIDTH        (WW),
        .PRED_WIDTH        (PW),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .masterClk          (masterClk),
        .resetN             (resetN),
        .pixelWord          (pixelWord),
        .pixelValid         (pixelValid),
        .pixelReady         (pixelReady),
        .readyForInputs     (readyForInputs),
        .inputsInbound      (inputsInbound),
        .inputPixel         (inputPixel),
        .predictionReady    (predictionReady),
        .predictionOut      (predictionOut),
        .predictionRecieved (predictionRecieved),
        .resultValid        (resultValid),
        .resultClass        (resultClass),
        .resultAck          (resultAck),
        .timeoutErr         (timeoutErr)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge masterClk) begin
        if (inputsInbound === 1'b1) begin
            blen++;
            if (exp_q.size() == 0) chk("pix_extra", 32'd1, 32'd0);
            else chk("pix", {31'd0, inputPixel}, {31'd0, exp_q.pop_front()});
        end
    end

    task automatic send_word(input int wi, input logic [WW-1:0] w);
        for (int i = 0; i < WW; i++)
            if (wi * WW + i < N) exp_q.push_back(w[i]);
        pixelValid = 1'b1;
        pixelWord  = w;
        @(posedge masterClk); #1;
        pixelValid = 1'b0;
        pixelWord  = '0;
    endtask

    task automatic stream(input int hold, input bit junk);
        int   b0;
        logic early;
        early = 1'b0;
        readyForInputs = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge masterClk); #1;
            if (inputsInbound) early = 1'b1;
        end
        if (hold > 0) chk("hold_idle", {31'd0, early}, 32'd0);
        b0 = blen;
        readyForInputs = 1'b1;
        @(posedge masterClk); #1;
        chk("rdy_lat", {31'd0, inputsInbound}, 32'd1);
        readyForInputs = 1'b0;
        if (junk) begin
            pixelValid = 1'b1;
            pixelWord  = '0;
        end
        for (int k = 0; k < 20; k++) begin
            if (!inputsInbound) break;
            @(posedge masterClk); #1;
            readyForInputs = k[0];
        end
        readyForInputs = 1'b0;
        chk("burst_end", {31'd0, inputsInbound}, 32'd0);
        chk("blen", blen - b0, N);
        chk("sb_empty", exp_q.size(), 32'd0);
        if (junk) begin
            chk("prdy_busy", {31'd0, pixelReady}, 32'd0);
            @(posedge masterClk); #1;
            pixelValid = 1'b0;
        end
    endtask

    task automatic predict(input logic [PW-1:0] p);
        predictionReady = 1'b1;
        predictionOut   = p;
        @(posedge masterClk); #1;
        chk("recv_lat", {31'd0, predictionRecieved}, 32'd1);
        @(posedge masterClk); #1;
        chk("recv_hold", {31'd0, predictionRecieved}, 32'd1);
        @(posedge masterClk); #1;
        predictionReady = 1'b0;
        predictionOut   = '0;
        @(posedge masterClk); #1;
        chk("recv_drop", {31'd0, predictionRecieved}, 32'd0);
        chk("rvalid", {31'd0, resultValid}, 32'd1);
        chk("rclass", {28'd0, resultClass}, {28'd0, p});
        repeat (3) begin
            @(posedge masterClk); #1;
        end
        chk("rvalid_hold", {31'd0, resultValid}, 32'd1);
        chk("rclass_hold", {28'd0, resultClass}, {28'd0, p});
        resultAck = 1'b1;
        @(posedge masterClk); #1;
        resultAck = 1'b0;
        chk("rvalid_clr", {31'd0, resultValid}, 32'd0);
        chk("prdy_back", {31'd0, pixelReady}, 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge masterClk);
        #1;
        chk("rst_prdy", {31'd0, pixelReady}, 32'd1);
        chk("rst_inb", {31'd0, inputsInbound}, 32'd0);
        chk("rst_pix", {31'd0, inputPixel}, 32'd0);
        chk("rst_recv", {31'd0, predictionRecieved}, 32'd0);
        chk("rst_rvalid", {31'd0, resultValid}, 32'd0);
        chk("rst_rclass", {28'd0, resultClass}, 32'd0);
        chk("rst_tout", {31'd0, timeoutErr}, 32'd0);
        resetN = 1'b1;

        resultAck = 1'b1;
        @(posedge masterClk); #1;
        resultAck = 1'b0;
        chk("ack_ignored", {31'd0, resultValid}, 32'd0);
        chk("ack_load", {31'd0, pixelReady}, 32'd1);

        send_word(0, 4'b0110);
        send_word(1, 4'b0001);
        chk("prdy_drop", {31'd0, pixelReady}, 32'd0);
        stream(10, 1'b0);
        predict(4'd7);

        send_word(0, 4'b1011);
        send_word(1, 4'b1110);
        stream(0, 1'b1);
        predict(4'd3);

        send_word(0, 4'b0101);
        send_word(1, 4'b0011);
        readyForInputs = 1'b1;
        @(posedge masterClk); #1;
        readyForInputs = 1'b0;
        chk("r_lat", {31'd0, inputsInbound}, 32'd1);
        repeat (3) begin
            @(posedge masterClk); #1;
        end
        #1 resetN = 1'b0;
        #1;
        chk("r_inb", {31'd0, inputsInbound}, 32'd0);
        chk("r_prdy", {31'd0, pixelReady}, 32'd1);
        chk("r_pix", {31'd0, inputPixel}, 32'd0);
        exp_q.delete();
        @(posedge masterClk); #1;
        resetN = 1'b1;

        send_word(0, 4'b1001);
        send_word(1, 4'b0010);
        stream(2, 1'b0);
        predict(4'd12);

`ifdef NN_STREAM_TIMEOUT_EN
        begin
            int n;
            n = 0;
            send_word(0, 4'b1100);
            send_word(1, 4'b0001);
            stream(0, 1'b0);
            for (int k = 0; k < 40; k++) begin
                @(posedge masterClk); #1;
                n++;
                if (resultValid) break;
            end
            chk("to_cycles", n, TO);
            chk("to_err", {31'd0, timeoutErr}, 32'd1);
            chk("to_rvalid", {31'd0, resultValid}, 32'd1);
            chk("to_class", {28'd0, resultClass}, 32'hF);
            chk("to_recv", {31'd0, predictionRecieved}, 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nn_image_streamer.md
Name: nn_image_streamer

Overview:
- Host-side driver for NN_Controler's pixel/prediction interface.
- Accepts a binarized image from the host as parallel words and buffers the whole image.
- Serializes the image onto inputPixel with a contiguous inputsInbound burst once the controller raises readyForInputs.
- Performs the predictionReady/predictionRecieved handshake and returns the class index to the host over a valid/ack port.

Parameters:
- INPUT_LAYER_NODES, 784, pixels per image (1 bit each).
- WORD_WIDTH, 8, pixels per host word.
- PRED_WIDTH, 4, width of predictionOut/resultClass.
- TIMEOUT_CYCLES, 4096, prediction watchdog limit (used only with NN_STREAM_TIMEOUT_EN).

Ports:
- masterClk  in  1  system clock, all state on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- pixelWord  in  WORD_WIDTH  host image word; bit i is pixel (wordIndex*WORD_WIDTH + i).
- pixelValid  in  1  host word valid.
- pixelReady  out  1  block accepts word (transfer = pixelValid & pixelReady).
- readyForInputs  in  1  from controller.
- inputsInbound  out  1  to controller; high for exactly INPUT_LAYER_NODES consecutive cycles.
- inputPixel  out  1  to controller; one pixel per cycle, index 0 first.
- predictionReady  in  1  from controller.
- predictionOut  in  PRED_WIDTH  from controller.
- predictionRecieved  out  1  to controller.
- resultValid  out  1  resultClass valid to host.
- resultClass  out  PRED_WIDTH  latched prediction.
- resultAck  in  1  host consumes result.
- timeoutErr  out  1  sticky watchdog flag (tied 0 without macro).

Behaviour:
- Reset values (async, resetN low): state=LOAD; all outputs 0 except pixelReady=1; image buffer, word counter and pixel counter cleared.
- NUM_WORDS = ceil(INPUT_LAYER_NODES/WORD_WIDTH). Bits of the last word beyond INPUT_LAYER_NODES are ignored.
- LOAD:
  - pixelReady=1.
  - Each transfer writes the word into the buffer at wordCount*WORD_WIDTH, then wordCount++.
  - On the transfer of word NUM_WORDS-1: pixelReady drops the next cycle and state -> WAIT_RDY.
- WAIT_RDY: when readyForInputs=1 -> STREAM. The first pixel is driven in the cycle after readyForInputs is sampled high.
- STREAM:
  - inputsInbound=1; inputPixel=buffer[pixCount]; pixCount increments each cycle.
  - After the cycle with pixCount=INPUT_LAYER_NODES-1, inputsInbound=0 and inputPixel=0 next cycle; state -> WAIT_PRED.
  - Burst is never interrupted; readyForInputs changes during STREAM are ignored.
- WAIT_PRED: when predictionReady=1, latch predictionOut into resultClass; state -> ACK.
- ACK:
  - predictionRecieved=1, held until predictionReady is sampled 0.
  - Then predictionRecieved=0, resultValid=1, state -> RESULT.
- RESULT:
  - resultValid and resultClass held stable until resultAck.
  - On resultAck: resultValid=0, counters cleared, pixelReady=1, state -> LOAD.
  - resultAck while resultValid=0 is ignored.
- Latency: readyForInputs high to first inputsInbound = 1 cycle. predictionReady high to predictionRecieved high = 1 cycle.
- pixelValid outside LOAD is ignored; no word is accepted and there is no overflow.
- Async reset mid-STREAM drops inputsInbound immediately. The image is discarded and must be reloaded.

Optional Feature:
- Macro NN_STREAM_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_PRED and ACK.
  - On reaching TIMEOUT_CYCLES: timeoutErr=1 (sticky until reset), resultClass={PRED_WIDTH{1}}, resultValid=1, predictionRecieved=0, state -> RESULT.
- Undefined: the counter is absent, timeoutErr is tied 0, and the block waits indefinitely.

Decomposition:
- Shared package (GlobalVariables.v) holds:
  - state encoding localparams (LOAD, WAIT_RDY, STREAM, WAIT_PRED, ACK, RESULT);
  - the NUM_WORDS ceil-div macro;
  - default INPUT_LAYER_NODES/PRED_WIDTH so the streamer and NN_Controler agree.
- One sub-module, nn_image_buffer: word-write, bit-read register array with wordCount/pixCount addressing. The FSM and handshakes stay in the top.

Test Plan:
- INPUT_LAYER_NODES=6, WORD_WIDTH=4; load 4'b0110 then 4'b0001, readyForInputs=1 -> inputsInbound high exactly 6 cycles, inputPixel = 0,1,1,0,1,0.
- Hold readyForInputs=0 for 10 cycles after load -> inputsInbound stays 0; it rises 1 cycle after readyForInputs goes high.
- predictionReady=1 with predictionOut=4'd7, held 3 cycles -> predictionRecieved high from next cycle until predictionReady low; then resultValid=1, resultClass=7, held until resultAck; pixelReady returns to 1.
- pixelValid pulsed during STREAM/WAIT_PRED -> no word accepted; next image loads correctly after resultAck.
- resetN low mid-STREAM (pixel 3) -> inputsInbound=0 asynchronously, pixelReady=1; a full reload gives a clean 6-cycle burst.
- NN_STREAM_TIMEOUT_EN, TIMEOUT_CYCLES=16, predictionReady never asserted -> after 16 cycles timeoutErr=1, resultValid=1, resultClass=4'hF.
